// File: rtl/dar_prgrm_ser_if.sv
// dar_prgrm_ser_if: command handshake, serial frame and error lines of dar_prgrm_ser.
// shadow_delay exists only when DAR_PRGRM_SHADOW_EN is defined.
interface dar_prgrm_ser_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_chan;
    logic [2:0] cmd_delay;
    logic       prgrm_go_;
    logic       prgrm_in;
    logic       err_;
    logic       err_clr;
    logic       err_sticky;
    logic       busy;
`ifdef DAR_PRGRM_SHADOW_EN
    logic [11:0] shadow_delay;
    modport master (output cmd_valid, cmd_chan, cmd_delay, err_, err_clr,
                    input cmd_ready, prgrm_go_, prgrm_in, err_sticky, busy, shadow_delay);
    modport slave  (input cmd_valid, cmd_chan, cmd_delay, err_, err_clr,
                    output cmd_ready, prgrm_go_, prgrm_in, err_sticky, busy, shadow_delay);
`else
    modport master (output cmd_valid, cmd_chan, cmd_delay, err_, err_clr,
                    input cmd_ready, prgrm_go_, prgrm_in, err_sticky, busy);
    modport slave  (input cmd_valid, cmd_chan, cmd_delay, err_, err_clr,
                    output cmd_ready, prgrm_go_, prgrm_in, err_sticky, busy);
`endif
endinterface

// File: rtl/dar_prgrm_ser.sv
// dar_prgrm_ser: FIFO-buffered serializer of (chan, delay) commands into 6-bit prgrm_go_/prgrm_in frames.
// DAR_PRGRM_SHADOW_EN adds per-channel shadow registers that suppress redundant frames.
module dar_prgrm_ser #(
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input logic            clk,
    input logic            rst,
    dar_prgrm_ser_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam int CW = (GAP > 6) ? $clog2(GAP + 1) : 3;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   bit_q, bit_d;
    logic [5:0]      sr_q, sr_d;
    logic            go_q, go_d, in_q, in_d;
    logic            ready_q, busy_q, err_q;
    logic [4:0]      mem_q [DEPTH];
    logic [AW-1:0]   wp_q, rp_q;
    logic [OW-1:0]   occ_q, occ_d;
    logic [4:0]      head;
    logic            push, pop, start, drop, empty;

    assign empty = occ_q == '0;
    assign head  = mem_q[rp_q];
    assign push  = bus.cmd_valid && ready_q;
    assign occ_d = occ_q + OW'(push) - OW'(pop);
    assign start = !empty && (state_q == S_IDLE || (state_q == S_GAP && bit_q == CW'(GAP - 1)));

`ifdef DAR_PRGRM_SHADOW_EN
    logic [11:0] shadow_q;
    assign drop             = shadow_q[3 * head[4:3] +: 3] == head[2:0];
    assign bus.shadow_delay = shadow_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) shadow_q <= '0;
        else if (state_q == S_SHIFT && bit_q == CW'(5)) shadow_q[3 * sr_q[2:1] +: 3] <= sr_q[5:3];
`else
    assign drop = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        go_d    = 1'b1;
        in_d    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            S_SHIFT: begin
                bit_d   = (bit_q == CW'(5)) ? '0 : bit_q + 1'b1;
                state_d = (bit_q == CW'(5)) ? S_GAP : S_SHIFT;
                go_d    = bit_q == CW'(5);
                in_d    = (bit_q == CW'(5)) ? 1'b0 : sr_q[3'(bit_q) + 3'd1];
            end
            S_GAP: begin
                bit_d   = bit_q + 1'b1;
                state_d = (bit_q == CW'(GAP - 1)) ? S_IDLE : S_GAP;
            end
            default: ;
        endcase
        // frame layout {delay, chan, write=0}; b0 leaves on the pop edge
        if (start) begin
            pop     = 1'b1;
            state_d = drop ? S_IDLE : S_SHIFT;
            bit_d   = '0;
            sr_d    = drop ? sr_q : {head[2:0], head[4:3], 1'b0};
            go_d    = drop;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= S_IDLE;
            bit_q   <= '0;
            sr_q    <= '0;
            go_q    <= 1'b1;
            in_q    <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            go_q    <= go_d;
            in_q    <= in_d;
            ready_q <= occ_d != OW'(DEPTH);
            busy_q  <= occ_d != '0 || state_d != S_IDLE;
            err_q   <= !bus.err_ || (err_q && !bus.err_clr);
            occ_q   <= occ_d;
            if (push) wp_q <= wp_q + 1'b1;
            if (pop) rp_q <= rp_q + 1'b1;
        end

    always_ff @(posedge clk)
        if (push) mem_q[wp_q] <= {bus.cmd_chan, bus.cmd_delay};

    assign bus.cmd_ready  = ready_q;
    assign bus.prgrm_go_  = go_q;
    assign bus.prgrm_in   = in_q;
    assign bus.err_sticky = err_q;
    assign bus.busy       = busy_q;
endmodule
